// File: rtl/cell_sched_pkg.sv
// rtl/cell_sched_pkg.sv - shared types and helpers for the cell transmit scheduler
//
// Purpose: scheduler FSM state encoding and the beat-count helper used to
// size a cell in payload beats.
// Ports: none (package).
package cell_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DAT_WIDTH beats needed to carry cell_size bits (ceiling division).
  function automatic int calc_transfers(input int cell_size, input int dat_width);
    return cell_size / dat_width + (((cell_size % dat_width) != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first active request at or after the priority pointer,
// wrapping around from N-1 to 0.
// Ports:
//   req  in  N          request vector
//   ptr  in  clog2(N)   port with highest priority
//   gnt  out N          one-hot winner (0 when no request)
//   idx  out clog2(N)   index of the winner (0 when no request)
//   any  out 1          at least one request is active
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      // Candidate port i places after the pointer, modulo N.
      j = int'(ptr) + i;
      if (j >= N) begin
        j = j - N;
      end
      if (!any && req[IW'(j)]) begin
        any          = 1'b1;
        gnt[IW'(j)]  = 1'b1;
        idx          = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cell_tx_sched.sv
// rtl/cell_tx_sched.sv - round-robin cell transmit scheduler
//
// Purpose: grants one of NUM_REQ requesters at a time and streams a whole
// cell of CELL_SIZE bits as TRANSFERS payload beats on a valid/ready bus.
// Optional feature macro: CELL_SCHED_PARITY_EN adds dat_par (even parity of dat).
// Ports:
//   clk        in  1                clock, rising edge
//   rst_n      in  1                asynchronous active-low reset
//   req        in  NUM_REQ          per-port request, level-sensitive
//   gnt        out NUM_REQ          one-hot grant, held for the whole cell
//   dat        out DAT_WIDTH        payload beat
//   dat_valid  out 1                beat valid
//   dat_ready  in  1                downstream accepts the beat
//   dat_last   out 1                final beat of the cell
//   dat_port   out clog2(NUM_REQ)   granted port index (0 when no grant)
//   dat_par    out 1                parity of dat (CELL_SCHED_PARITY_EN only)
//   cell_done  out 1                pulse after the last beat is accepted
module cell_tx_sched
  import cell_sched_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter int          DAT_WIDTH = 32,
  parameter int          CELL_SIZE = 424,
  parameter logic [31:0] PAY_INIT  = 32'h01020304,
  parameter logic [31:0] PAY_INC   = 32'h01010101
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [DAT_WIDTH-1:0]       dat,
  output logic                       dat_valid,
  input  logic                       dat_ready,
  output logic                       dat_last,
  output logic [$clog2(NUM_REQ)-1:0] dat_port,
`ifdef CELL_SCHED_PARITY_EN
  output logic                       dat_par,
`endif
  output logic                       cell_done
);

  localparam int TRANSFERS = calc_transfers(CELL_SIZE, DAT_WIDTH);
  localparam int BW        = $clog2(TRANSFERS + 1);
  localparam int IW        = $clog2(NUM_REQ);
  localparam logic [BW-1:0] LAST_BEAT = BW'(TRANSFERS - 1);

  state_t state, state_nxt;
  logic [BW-1:0]        beat, beat_nxt;
  logic [IW-1:0]        ptr, ptr_nxt;
  logic [NUM_REQ-1:0]   gnt_nxt;
  logic [DAT_WIDTH-1:0] dat_nxt;
  logic                 valid_nxt;
  logic                 last_nxt;
  logic [IW-1:0]        port_nxt;
  logic                 done_nxt;

  logic [NUM_REQ-1:0]   win_oh;
  logic [IW-1:0]        win_idx;
  logic                 win_any;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (win_oh),
    .idx (win_idx),
    .any (win_any)
  );

  // Payload word for a beat: 32-bit wrapping sum, then truncated or
  // zero-extended to the bus width.
  function automatic logic [DAT_WIDTH-1:0] payload(input logic [BW-1:0] b);
    logic [31:0] s;
    s = PAY_INIT + 32'(b) * PAY_INC;
    return DAT_WIDTH'(s);
  endfunction

  // Every output is computed here one cycle ahead and registered below.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    dat_nxt   = dat;
    valid_nxt = dat_valid;
    last_nxt  = dat_last;
    port_nxt  = dat_port;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (win_any) begin
          state_nxt = SEND;
          beat_nxt  = '0;
          gnt_nxt   = win_oh;
          port_nxt  = win_idx;
          valid_nxt = 1'b1;
          dat_nxt   = payload('0);
          last_nxt  = (TRANSFERS == 1);
          // The port after the winner gets top priority next time.
          ptr_nxt   = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      SEND: begin
        if (dat_valid && dat_ready) begin
          if (beat == LAST_BEAT) begin
            state_nxt = DONE;
            beat_nxt  = '0;
            gnt_nxt   = '0;
            port_nxt  = '0;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            dat_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            beat_nxt  = beat + 1'b1;
            dat_nxt   = payload(beat + 1'b1);
            last_nxt  = ((beat + 1'b1) == LAST_BEAT);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      ptr       <= '0;
      gnt       <= '0;
      dat       <= '0;
      dat_valid <= 1'b0;
      dat_last  <= 1'b0;
      dat_port  <= '0;
      cell_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat      <= beat_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      dat       <= dat_nxt;
      dat_valid <= valid_nxt;
      dat_last  <= last_nxt;
      dat_port  <= port_nxt;
      cell_done <= done_nxt;
    end
  end

`ifdef CELL_SCHED_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_par <= 1'b0;
    end else begin
      dat_par <= ^dat_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_cell_tx_sched.sv
// tb/tb_cell_tx_sched.sv - self-checking bench for cell_tx_sched
module tb_cell_tx_sched;

  localparam int T = 14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [31:0] dat;
  logic        dat_valid;
  logic        dat_ready;
  logic        dat_last;
  logic [1:0]  dat_port;
  logic        cell_done;

  logic [3:0]  req_w;
  logic        ready_w;
  logic [3:0]  g8, g40;
  logic [7:0]  d8;
  logic [39:0] d40;
  logic        v8, v40, l8, l40, c8, c40;
  logic [1:0]  p8, p40;
`ifdef CELL_SCHED_PARITY_EN
  logic        dat_par, par8, par40;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cell_tx_sched dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .dat(dat),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_last(dat_last),
    .dat_port(dat_port),
`ifdef CELL_SCHED_PARITY_EN
    .dat_par(dat_par),
`endif
    .cell_done(cell_done)
  );

  cell_tx_sched #(.DAT_WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .req(req_w), .gnt(g8), .dat(d8),
    .dat_valid(v8), .dat_ready(ready_w), .dat_last(l8), .dat_port(p8),
`ifdef CELL_SCHED_PARITY_EN
    .dat_par(par8),
`endif
    .cell_done(c8)
  );

  cell_tx_sched #(.DAT_WIDTH(40)) u_w40 (
    .clk(clk), .rst_n(rst_n), .req(req_w), .gnt(g40), .dat(d40),
    .dat_valid(v40), .dat_ready(ready_w), .dat_last(l40), .dat_port(p40),
`ifdef CELL_SCHED_PARITY_EN
    .dat_par(par40),
`endif
    .cell_done(c40)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  port;
    logic [31:0] dat;
    logic        last;
  } beat_t;
  beat_t sb[$];

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_gnt;
    logic [1:0] exp_port;
    bit         bp;
  } vec_t;
  vec_t vecs[10];

  function automatic logic [31:0] model_dat(input int b);
    return 32'h01020304 + 32'(b) * 32'h01010101;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_cell(input int p);
    for (int b = 0; b < T; b++) begin
      sb.push_back('{port: 2'(p), dat: model_dat(b), last: (b == T - 1)});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and handshake-stability monitor, sampled mid-cycle.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat;
  logic        prev_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(dat_valid), 64'd1);
        check("hold_dat", 64'(dat), 64'(prev_dat));
        check("hold_last", 64'(dat_last), 64'(prev_last));
      end
      if (dat_valid) begin
        check("gnt_onehot", 64'(gnt), 64'(4'b0001 << dat_port));
`ifdef CELL_SCHED_PARITY_EN
        check("parity", 64'(dat_par), 64'(^dat));
`endif
      end
      if (dat_valid && dat_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: unexpected beat dat=%0h", dat);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("sb_port", 64'(dat_port), 64'(e.port));
          check("sb_dat", 64'(dat), 64'(e.dat));
          check("sb_last", 64'(dat_last), 64'(e.last));
        end
      end
      prev_stall = dat_valid && !dat_ready;
      prev_dat   = dat;
      prev_last  = dat_last;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    step();
    rst_n = 1'b1;
    sb.delete();
  endtask

  // Waits for cell_done, checks the pulse and the return to idle.
  task automatic finish_cell(input logic [3:0] held, input bit bp);
    logic [3:0] pat;
    int k;
    bit seen;
    pat  = 4'b1001;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 300) begin
      dat_ready = bp ? pat[k % 4] : 1'b1;
      step();
      k++;
      if (cell_done) begin
        seen = 1'b1;
      end else begin
        check("gnt_held", 64'(gnt), 64'(held));
      end
    end
    dat_ready = 1'b1;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL cell_timeout: cell_done not seen got 0 expected 1");
    end
    check("done_gnt", 64'(gnt), 64'd0);
    check("done_valid", 64'(dat_valid), 64'd0);
    step();
    check("done_pulse", 64'(cell_done), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int prev_cyc;
    int k;
    int cnt8, cnt40, nl8, nl40;
    logic [7:0]  last8;
    logic [39:0] last40;

    vecs[0] = '{4'b0001, 4'b0001, 2'd0, 1'b0};
    vecs[1] = '{4'b1111, 4'b0010, 2'd1, 1'b1};
    vecs[2] = '{4'b1111, 4'b0100, 2'd2, 1'b0};
    vecs[3] = '{4'b1111, 4'b1000, 2'd3, 1'b0};
    vecs[4] = '{4'b1111, 4'b0001, 2'd0, 1'b0};
    vecs[5] = '{4'b0001, 4'b0001, 2'd0, 1'b0};
    vecs[6] = '{4'b1001, 4'b1000, 2'd3, 1'b1};
    vecs[7] = '{4'b0110, 4'b0010, 2'd1, 1'b0};
    vecs[8] = '{4'b0011, 4'b0001, 2'd0, 1'b0};
    vecs[9] = '{4'b1100, 4'b0100, 2'd2, 1'b0};

    req       = '0;
    req_w     = '0;
    ready_w   = 1'b1;
    dat_ready = 1'b1;
    do_reset();

    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_dat", 64'(dat), 64'd0);
    check("rst_valid", 64'(dat_valid), 64'd0);
    check("rst_last", 64'(dat_last), 64'd0);
    check("rst_port", 64'(dat_port), 64'd0);
    check("rst_done", 64'(cell_done), 64'd0);
`ifdef CELL_SCHED_PARITY_EN
    check("rst_par", 64'(dat_par), 64'd0);
`endif

    // Round-robin with all requests held: ports 0,1,2,3,0, TRANSFERS+2 apart.
    push_cell(0); push_cell(1); push_cell(2); push_cell(3); push_cell(0);
    req      = 4'b1111;
    prev_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      k = 0;
      while (gnt == 4'b0000 && k < 40) begin
        step();
        k++;
      end
      check("rr_gnt", 64'(gnt), 64'(4'b0001 << (g % 4)));
      if (g > 0) check("rr_period", 64'(cyc - prev_cyc), 64'(T + 2));
      prev_cyc = cyc;
      if (g == 4) req = '0;
      k = 0;
      while (gnt != 4'b0000 && k < 40) begin
        step();
        k++;
      end
      check("rr_release", 64'(gnt), 64'd0);
    end
    step();
    step();
    check("rr_sb_drained", 64'(sb.size()), 64'd0);

    // Table-driven cells, pointer starting from port 0.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      req = vecs[i].req;
      push_cell(int'(vecs[i].exp_port));
      step();
      check("vec_gnt", 64'(gnt), 64'(vecs[i].exp_gnt));
      check("vec_port", 64'(dat_port), 64'(vecs[i].exp_port));
      check("vec_beat0", 64'(dat), 64'(model_dat(0)));
      req = '0;
      finish_cell(vecs[i].exp_gnt, vecs[i].bp);
    end

    // Reset in the middle of a cell, then a fresh cell for port 1.
    req = 4'b0001;
    push_cell(0);
    step();
    req = '0;
    for (int b = 0; b < 5; b++) step();
    check("mid_beat5", 64'(dat), 64'(model_dat(5)));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 64'(gnt), 64'd0);
    check("mid_rst_dat", 64'(dat), 64'd0);
    check("mid_rst_valid", 64'(dat_valid), 64'd0);
    check("mid_rst_last", 64'(dat_last), 64'd0);
    check("mid_rst_port", 64'(dat_port), 64'd0);
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    req   = 4'b0010;
    push_cell(1);
    step();
    check("post_rst_gnt", 64'(gnt), 64'b0010);
    check("post_rst_dat", 64'(dat), 64'(model_dat(0)));
    req = '0;
    finish_cell(4'b0010, 1'b0);

    // Width variants: 8-bit gives 53 beats, 40-bit gives 11 beats.
    cnt8 = 0; cnt40 = 0; nl8 = 0; nl40 = 0;
    last8 = '0; last40 = '0;
    req_w = 4'b0001;
    for (int c = 0; c < 120; c++) begin
      step();
      req_w = '0;
      if (v8) cnt8++;
      if (v8 && l8) begin nl8++; last8 = d8; end
      if (v40) cnt40++;
      if (v40 && l40) begin nl40++; last40 = d40; end
    end
    check("w8_beats", 64'(cnt8), 64'd53);
    check("w8_nlast", 64'(nl8), 64'd1);
    check("w8_last_dat", 64'(last8), 64'h38);
    check("w40_beats", 64'(cnt40), 64'd11);
    check("w40_nlast", 64'(nl40), 64'd1);
    check("w40_last_dat", 64'(last40), 64'h000B0C0D0E);
    check("w_idle", 64'({g8, g40, p8, p40, c8, c40}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
